// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit: slot record,
// select-width helper and default parameter values.
package fwd_pkg;
  localparam int DEF_NUM_SRC    = 2;
  localparam int DEF_FWD_STAGES = 2;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_CNT_W      = 16;

  // Slot rd field is sized for the widest supported register address.
  localparam int MAX_REG_AW     = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  we;
    logic                  is_load;
  } slot_t;

  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/fwd_slot_pipe.sv
// Producer slot shift register: index 0 is slot 1 (youngest in flight).
// Flush kills the incoming entry and the one moving into slot 2.
module fwd_slot_pipe
  import fwd_pkg::*;
#(
  parameter int FWD_STAGES = DEF_FWD_STAGES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  slot_t                  i_slot,
  output slot_t [FWD_STAGES-1:0] o_slots
);

  slot_t [FWD_STAGES-1:0] r_slots;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots <= '0;
    end else begin
      r_slots[0] <= i_flush ? '0 : i_slot;
      for (int k = 1; k < FWD_STAGES; k++) begin
        r_slots[k] <= (k == 1 && i_flush) ? '0 : r_slots[k-1];
      end
    end
  end

  assign o_slots = r_slots;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Decode-stage forwarding select, load-use and long-op scoreboard stall
// generation, plus a saturating stall-cycle counter.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC    = DEF_NUM_SRC,
  parameter  int FWD_STAGES = DEF_FWD_STAGES,
  parameter  int REG_AW     = DEF_REG_AW,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int SEL_W      = sel_w(FWD_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_we,
  input  logic                      id_is_load,
  input  logic                      id_is_long,
  input  logic                      long_done,
  input  logic [REG_AW-1:0]         long_done_rd,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  slot_t [FWD_STAGES-1:0] w_slots;
  slot_t                  w_slot_in;
  logic [REG_AW-1:0]      w_rs [NUM_SRC];
  logic [NUM_SRC-1:0]     w_src_live;
  logic [2**REG_AW-1:0]   r_busy;
  logic [2**REG_AW-1:0]   w_busy_nxt;
  logic [CNT_W-1:0]       r_stall_cnt;
  logic                   w_load_use;
  logic                   w_busy_hit;
  logic                   w_issue;
  logic                   w_unused_load;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_rs[i]       = id_rs[i*REG_AW +: REG_AW];
    assign w_src_live[i] = id_rs_used[i] && (w_rs[i] != '0);
  end

  // Oldest-to-youngest scan so the youngest matching slot overwrites the select.
  always_comb begin
    fwd_sel    = '0;
    w_load_use = 1'b0;
    w_busy_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_src_live[i]) begin
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
          if (w_slots[k].valid && w_slots[k].we &&
              w_slots[k].rd == MAX_REG_AW'(w_rs[i])) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
        if (w_slots[0].valid && w_slots[0].we && w_slots[0].is_load &&
            w_slots[0].rd == MAX_REG_AW'(w_rs[i])) begin
          w_load_use = 1'b1;
        end
        if (r_busy[w_rs[i]]) begin
          w_busy_hit = 1'b1;
        end
      end
    end
    if (id_we && id_rd != '0 && r_busy[id_rd]) begin
      w_busy_hit = 1'b1;
    end
  end

  always_comb begin
    w_unused_load = 1'b0;
    for (int k = 1; k < FWD_STAGES; k++) begin
      w_unused_load = w_unused_load ^ w_slots[k].is_load;
    end
  end

  assign stall   = id_valid && !flush && (w_load_use || w_busy_hit);
  assign w_issue = id_valid && !stall && !flush;

  // Long ops enter the pipe as non-writers; their result is tracked by r_busy.
  always_comb begin
    w_slot_in         = '0;
    w_slot_in.valid   = w_issue;
    w_slot_in.rd      = w_issue ? MAX_REG_AW'(id_rd) : '0;
    w_slot_in.we      = w_issue && id_we && !id_is_long;
    w_slot_in.is_load = w_issue && id_is_load;
  end

  fwd_slot_pipe #(
    .FWD_STAGES (FWD_STAGES)
  ) u_slot_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_slot  (w_slot_in),
    .o_slots (w_slots)
  );

  always_comb begin
    w_busy_nxt = r_busy;
    if (long_done) begin
      w_busy_nxt[long_done_rd] = 1'b0;
    end
    if (w_issue && id_is_long && id_we && id_rd != '0) begin
      w_busy_nxt[id_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: default instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_forwarding_hazard_unit;

  localparam int SW = 2;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_is_load;
  logic        id_is_long;
  logic        long_done;
  logic [4:0]  long_done_rd;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [3:0]  sat_fwd_sel;
  logic        sat_stall;
  logic [1:0]  sat_cnt;

  int total = 0;
  int bad   = 0;

  forwarding_hazard_unit u_dut (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_rs (id_rs),
    .id_rs_used (id_rs_used), .id_rd (id_rd), .id_we (id_we),
    .id_is_load (id_is_load), .id_is_long (id_is_long), .long_done (long_done),
    .long_done_rd (long_done_rd), .flush (flush), .fwd_sel (fwd_sel),
    .stall (stall), .stall_cnt (stall_cnt)
  );

  forwarding_hazard_unit #(.CNT_W (2)) u_sat (
    .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_rs (id_rs),
    .id_rs_used (id_rs_used), .id_rd (id_rd), .id_we (id_we),
    .id_is_load (id_is_load), .id_is_long (id_is_long), .long_done (long_done),
    .long_done_rd (long_done_rd), .flush (flush), .fwd_sel (sat_fwd_sel),
    .stall (sat_stall), .stall_cnt (sat_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] fsel(input int i);
    return fwd_sel[i*SW +: SW];
  endfunction

  // Driver tasks: inputs change at posedge+1, checks happen near the negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic we, input logic ld, input logic lg);
    id_valid   = v;
    id_rs      = {rs2, rs1};
    id_rs_used = used;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
    id_is_long = lg;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    long_done    = 1'b0;
    long_done_rd = 5'd0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    total++; if (fwd_sel !== 4'd0) begin bad++; $display("FAIL rst_fwd got=%0h exp=0", fwd_sel); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    idle();
    #1;
    rst_n = 1'b1;
    cyc();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt_after got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_fwd_basic();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd5, 5'd5, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (fsel(0) !== 2'd1) begin bad++; $display("FAIL fwd_s1 got=%0d exp=1", fsel(0)); end
    total++; if (fsel(1) !== 2'd0) begin bad++; $display("FAIL fwd_unused got=%0d exp=0", fsel(1)); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_s1_stall got=%0b exp=0", stall); end
    cyc();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    idle();
    cyc();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (fsel(0) !== 2'd2) begin bad++; $display("FAIL fwd_s2 got=%0d exp=2", fsel(0)); end
    cyc();
    idle();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    drive(1'b0, 5'd5, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    #4;
    total++; if (fsel(1) !== 2'd1) begin bad++; $display("FAIL young_rs2 got=%0d exp=1", fsel(1)); end
    total++; if (fsel(0) !== 2'd0) begin bad++; $display("FAIL young_unused_rs1 got=%0d exp=0", fsel(0)); end
    cyc();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #4;
    total++; if (fwd_sel !== 4'd0) begin bad++; $display("FAIL x0_fwd got=%0h exp=0", fwd_sel); end
    cyc();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_issue_stall got=%0b exp=0", stall); end
    cyc();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_use_stall got=%0b exp=1", stall); end
    cyc();
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_after_stall got=%0b exp=0", stall); end
    total++; if (fsel(0) !== 2'd2) begin bad++; $display("FAIL ld_after_fwd got=%0d exp=2", fsel(0)); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL ld_cnt got=%0d exp=1", stall_cnt); end
    cyc();
    idle();
  endtask

  task automatic test_long();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1);
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL long_issue_stall got=%0b exp=0", stall); end
    cyc();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL long_raw_stall got=%0b exp=1", stall); end
    total++; if (fsel(0) !== 2'd0) begin bad++; $display("FAIL long_no_fwd got=%0d exp=0", fsel(0)); end
    cyc();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL long_waw_stall got=%0b exp=1", stall); end
    cyc();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
    long_done    = 1'b1;
    long_done_rd = 5'd9;
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL long_done_cycle_stall got=%0b exp=1", stall); end
    cyc();
    long_done = 1'b0;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL long_after_done_stall got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL long_cnt got=%0d exp=3", stall_cnt); end
    cyc();
    idle();
  endtask

  task automatic test_same_cycle_busy();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0, 1'b1);
    long_done    = 1'b1;
    long_done_rd = 5'd9;
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sc_issue_stall got=%0b exp=0", stall); end
    cyc();
    long_done = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sc_cleared_stall got=%0b exp=0", stall); end
    id_rs = {5'd0, 5'd10};
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sc_set_stall got=%0b exp=1", stall); end
    idle();
    cyc();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    cyc();
    flush = 1'b0;
    #3;
    total++; if (fsel(0) !== 2'd0) begin bad++; $display("FAIL flush_slots_fwd got=%0d exp=0", fsel(0)); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_slots_stall got=%0b exp=0", stall); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", stall_cnt); end
    cyc();
    idle();
  endtask

  task automatic test_reset_mid_long();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
    #4;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rml_stall got=%0b exp=1", stall); end
    cyc();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL rml_cnt_pre got=%0d exp=1", stall_cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rml_cnt_rst got=%0d exp=0", stall_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rml_busy_cleared got=%0b exp=0", stall); end
    rst_n = 1'b1;
    cyc();
    long_done    = 1'b1;
    long_done_rd = 5'd9;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rml_late_done got=%0b exp=0", stall); end
    cyc();
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) cyc();
    total++; if (sat_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", sat_cnt); end
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", stall_cnt); end
    total++; if (sat_stall !== 1'b1) begin bad++; $display("FAIL sat_stall got=%0b exp=1", sat_stall); end
    long_done    = 1'b1;
    long_done_rd = 5'd9;
    cyc();
    idle();
    cyc();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    test_reset();
    test_fwd_basic();
    test_youngest();
    test_load_use();
    test_long();
    test_same_cycle_busy();
    test_flush();
    test_reset_mid_long();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of source operands checked per instruction (2..3).
REQ-002 SHALL have parameter FWD_STAGES, default 2, number of tracked producer slots (1..4).
REQ-003 SHALL have parameter REG_AW, default 5, register address width.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port id_valid, input, 1 bit, decode stage holds an instruction.
REQ-009 SHALL have port id_rs, input, NUM_SRC*REG_AW bits, source addresses; source i is at bits [i*REG_AW +: REG_AW].
REQ-010 SHALL have port id_rs_used, input, NUM_SRC bits, source i is read.
REQ-011 SHALL have port id_rd, input, REG_AW bits, destination address.
REQ-012 SHALL have port id_we, input, 1 bit, instruction writes id_rd.
REQ-013 SHALL have port id_is_load, input, 1 bit, instruction is a load.
REQ-014 SHALL have port id_is_long, input, 1 bit, instruction is a multi-cycle op (divide).
REQ-015 SHALL have port long_done, input, 1 bit, a long op completes this cycle.
REQ-016 SHALL have port long_done_rd, input, REG_AW bits, destination of the completing long op.
REQ-017 SHALL have port flush, input, 1 bit, kill the decode instruction and the slot-1 instruction.
REQ-018 SHALL have port fwd_sel, output, NUM_SRC*SEL_W bits, per-source forward select, SEL_W = clog2(FWD_STAGES+1).
REQ-019 SHALL have port stall, output, 1 bit, hold decode this cycle.
REQ-020 SHALL have port stall_cnt, output, CNT_W bits, saturating count of stalled cycles.

Function
REQ-021 SHALL keep FWD_STAGES slots {valid, rd, we, is_load}; slot 1 is the youngest in-flight instruction.
REQ-022 SHALL shift the slots every clock: slot[k+1] <= slot[k]; slot[1] <= decode info when issue, otherwise a bubble (valid=0).
REQ-023 SHALL define issue = id_valid and not stall and not flush.
REQ-024 SHALL enter an issued long op into slot 1 with we=0.
REQ-025 SHALL drive fwd_sel[i] combinationally to the smallest k where slot k is valid with we=1, rd==rs[i] and rd!=0; otherwise 0, youngest match winning.
REQ-026 SHALL force fwd_sel[i]=0 when id_rs_used[i]=0 or rs[i]=0.
REQ-027 SHALL assert stall (load-use) when any used nonzero source matches valid slot 1 with we=1 and is_load=1.
REQ-028 SHALL keep a REG-wide busy vector: bit id_rd is set on issue of a long op with id_we=1 and id_rd!=0; bit long_done_rd is cleared on long_done.
REQ-029 SHALL assert stall when id_valid and any used source, or id_rd with id_we=1, has its registered busy bit set.
REQ-030 SHALL keep stall asserted during the long_done cycle, since busy clears at the following edge.
REQ-031 SHALL apply a clear and a set of different bits in the same cycle together.
REQ-032 SHALL treat x0 as never busy and never forwarded.
REQ-033 SHALL on flush force slot[1] <= bubble and slot[2] <= bubble, not issue, and leave busy untouched.
REQ-034 SHALL gate stall to 0 when id_valid=0 or flush=1.
REQ-035 SHALL increment stall_cnt on each cycle with stall=1 and saturate at all-ones.

Reset
REQ-036 SHALL, while rst_n=0, asynchronously set all slots invalid, busy=0 and stall_cnt=0.
REQ-037 SHALL then hold fwd_sel=0 and stall=0.
REQ-038 SHALL, on reset mid long op, drop the pending busy state; a later long_done for it is harmless.

Structure
REQ-039 SHALL place the slot struct type, the SEL_W function and the default parameter constants in shared package fwd_pkg.
REQ-040 SHALL implement the slot shift register as the sub-module fwd_slot_pipe; the comparators, busy vector and counter live in the top.

Verification
REQ-041 SHALL check: issue add x5, then next cycle rs1=x5 -> fwd_sel[0]=1, stall=0; one bubble later -> fwd_sel[0]=2.
REQ-042 SHALL check: x5 written in slots 1 and 2, rs2=x5 -> fwd_sel[1]=1 (youngest wins); rd=x0 producer -> 0.
REQ-043 SHALL check: load x7, then dependent rs1=x7 -> stall=1 for 1 cycle, stall_cnt=1, then fwd_sel[0]=2.
REQ-044 SHALL check: long op writing x9, dependent waits; long_done rd=9 at cycle N -> stall still 1 at N, 0 at N+1.
REQ-045 SHALL check: flush with load in slot 1 and dependent in decode -> stall=0; next cycle slots 1-2 are invalid.
REQ-046 SHALL check: rst_n low mid long op -> busy cleared, stall_cnt=0; CNT_W=2 with 5 stalls -> stall_cnt=3.
